// File: rtl/contador_bcd.sv
// Two-digit BCD up/down counter with start/stop FSM, load and clock prescaler.
// Optional leading-zero blanking of the tens digit: define CONTADOR_BCD_APAGA_ZERO_EN.
module contador_bcd #(
    parameter int DIV = 50000000,
    parameter int MAX = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       parar,
    input  logic       direcao,
    input  logic       carregar,
    input  logic [7:0] valor_carga,
    output logic [3:0] unidade,
    output logic [3:0] dezena,
    output logic       contando,
    output logic       fim
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_TOP = PW'(DIV - 1);
    localparam logic [3:0] MAX_DEZ = 4'(MAX / 10);
    localparam logic [3:0] MAX_UNI = 4'(MAX % 10);
    localparam logic [7:0] MAX_BCD = {MAX_DEZ, MAX_UNI};

    typedef enum logic {
        PARADO   = 1'b0,
        CONTANDO = 1'b1
    } estado_t;

    estado_t       estado_q;
    logic [PW-1:0] presc_q;
    logic [3:0]    uni_q;
    logic [3:0]    dez_q;
    logic          fim_q;

    logic [3:0]    carga_uni;
    logic [3:0]    carga_dez;
    logic [7:0]    carga_d;
    logic [7:0]    passo_d;
    logic          volta_d;

    // Load value: clamp each digit to 9, then clamp the whole value to MAX.
    // Packed BCD compares in the same order as the decimal value.
    always_comb begin
        carga_uni = (valor_carga[3:0] > 4'd9) ? 4'd9 : valor_carga[3:0];
        carga_dez = (valor_carga[7:4] > 4'd9) ? 4'd9 : valor_carga[7:4];
        carga_d   = {carga_dez, carga_uni};
        if (carga_d > MAX_BCD) begin
            carga_d = MAX_BCD;
        end
    end

    always_comb begin
        passo_d = {dez_q, uni_q};
        volta_d = 1'b0;
        if (direcao) begin
            if ({dez_q, uni_q} == MAX_BCD) begin
                passo_d = 8'h00;
                volta_d = 1'b1;
            end else if (uni_q == 4'd9) begin
                passo_d = {dez_q + 4'd1, 4'd0};
            end else begin
                passo_d = {dez_q, uni_q + 4'd1};
            end
        end else begin
            if ({dez_q, uni_q} == 8'h00) begin
                passo_d = MAX_BCD;
                volta_d = 1'b1;
            end else if (uni_q == 4'd0) begin
                passo_d = {dez_q - 4'd1, 4'd9};
            end else begin
                passo_d = {dez_q, uni_q - 4'd1};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= PARADO;
            presc_q  <= '0;
            uni_q    <= 4'd0;
            dez_q    <= 4'd0;
            fim_q    <= 1'b0;
        end else begin
            fim_q <= 1'b0;
            case (estado_q)
                PARADO: begin
                    presc_q <= '0;
                    if (carregar) begin
                        {dez_q, uni_q} <= carga_d;
                    end else if (iniciar && !parar) begin
                        estado_q <= CONTANDO;
                    end
                end
                CONTANDO: begin
                    if (carregar) begin
                        {dez_q, uni_q} <= carga_d;
                        presc_q        <= '0;
                    end else if (parar) begin
                        estado_q <= PARADO;
                        presc_q  <= '0;
                    end else if (presc_q == PRESC_TOP) begin
                        // Step lands on the same edge the prescaler wraps.
                        presc_q        <= '0;
                        {dez_q, uni_q} <= passo_d;
                        fim_q          <= volta_d;
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                default: begin
                    estado_q <= PARADO;
                    presc_q  <= '0;
                end
            endcase
        end
    end

    assign unidade  = uni_q;
    assign contando = (estado_q == CONTANDO);
    assign fim      = fim_q;

`ifdef CONTADOR_BCD_APAGA_ZERO_EN
    // 4'hF is outside BCD, so the downstream decoder blanks the digit.
    assign dezena = (dez_q == 4'd0) ? 4'hF : dez_q;
`else
    assign dezena = dez_q;
`endif

endmodule

// File: doc/contador_bcd.md
Name: contador_bcd

Overview:
- Two-digit BCD up/down counter with a start/stop state machine and a clock prescaler.
- Drives the unit and tens digit inputs of the two 7-segment decoders: `unidade` and `dezena` each feed one decoder's 4-bit input directly.
- Sits directly upstream of the display decoders.
- Provides load, direction control and a wrap pulse for the surrounding control logic.

Parameters:
- DIV, 50000000: clock cycles per count step. Must be >= 2.
- MAX, 99: terminal count, decimal 1..99. The counter range is 0..MAX.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- iniciar  in  1  start request, sampled each clock.
- parar  in  1  stop request, sampled each clock.
- direcao  in  1  count direction: 1 = up, 0 = down. Sampled at each step.
- carregar  in  1  synchronous load strobe.
- valor_carga  in  8  load value, BCD: [7:4] tens, [3:0] units.
- unidade  out  4  units digit, BCD, registered.
- dezena  out  4  tens digit, BCD, registered.
- contando  out  1  1 when the FSM is in state CONTANDO.
- fim  out  1  one-cycle pulse on wrap-around.

Behaviour:
- Reset (asynchronous, active-high; holds while asserted):
  - unidade=0, dezena=0, contando=0, fim=0.
  - FSM goes to PARADO; prescaler goes to 0.
- FSM states and transitions:
  - PARADO: carregar -> PARADO (load); iniciar & !parar -> CONTANDO; otherwise hold.
  - CONTANDO: parar -> PARADO; carregar -> CONTANDO (load, prescaler cleared); otherwise count.
  - Priority: reset > carregar > parar > iniciar.
  - iniciar and parar asserted together -> parar wins.
- Prescaler:
  - Width $clog2(DIV). Counts only in CONTANDO.
  - When it reaches DIV-1, it returns to 0 and one step occurs on that same edge.
  - Cleared to 0 on load and whenever the FSM is in PARADO.
  - First step occurs exactly DIV clocks after the edge that entered CONTANDO.
- Step, up (direcao=1):
  - unidade 9 -> 0 with dezena+1.
  - If {dezena,unidade} equals MAX in BCD, the next value is 00 and fim=1 for that one cycle.
- Step, down (direcao=0):
  - unidade 0 -> 9 with dezena-1.
  - If the value is 00, the next value is MAX in BCD and fim=1 for one cycle.
- Load:
  - Any digit >9 is clamped to 9.
  - If the clamped value exceeds MAX, MAX is loaded.
  - Load takes effect on the edge where carregar=1. Outputs show the loaded value the next cycle.
  - Load never generates fim.
- Outputs:
  - unidade and dezena are always valid BCD (0..9). The counter never leaves 0..MAX.
  - fim is low at all cycles except the wrap step.
  - Reset mid-count clears everything immediately, without waiting for a clock edge.
- Timing: no combinational path from any input to any output.

Optional Feature:
- Macro: CONTADOR_BCD_APAGA_ZERO_EN.
- Defined (leading-zero blanking):
  - When the true tens digit is 0, dezena outputs 4'b1111. The downstream decoder maps this to its default code, so all segments are off.
  - unidade is unaffected.
  - Internal counting uses the true tens value.
  - After reset, dezena=4'b1111.
- Undefined: dezena outputs the true tens digit, including 0.

Test Plan (DIV=4, MAX=99 unless stated):
- Reset, then iniciar pulse, direcao=1, run 40 clocks -> value steps every 4 clocks: 00,01,...,09,10. Verify dezena=1, unidade=0 at step 10, with fim=0 throughout.
- Load 8'h98, iniciar, direcao=1 -> 98, 99, 00. fim=1 for exactly one cycle on the 99->00 edge.
- MAX=59, load 8'h00, direcao=0, iniciar -> next step gives 59 with a one-cycle fim pulse, then 58.
- Load 8'hAF with MAX=99 -> 99 loaded. Load 8'h75 with MAX=59 -> 59 loaded. No fim in either case.
- While counting at 42, assert parar and iniciar together -> PARADO, contando=0, value holds at 42 for 20 clocks. Then assert reset asynchronously mid-cycle -> outputs read 00 before the next clock edge.
- With CONTADOR_BCD_APAGA_ZERO_EN defined:
  - After reset -> dezena=4'hF.
  - Count 09 -> 10 -> dezena=4'h1.
  - Wrap 99 -> 00 -> dezena=4'hF, unidade=0.
